// File: rtl/keccak_perm_sequencer.sv
// Control sequencer for an unrolled Keccak-f[1600] core: input beat tracking,
// round iteration and 8-beat output unload scheduling. Carries no state data.
module keccak_perm_sequencer #(
  parameter int LAYERS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pushin,
  input  logic [2:0] dix,
  output logic [7:0] in_we,
  output logic       core_load,
  output logic       core_en,
  output logic [4:0] round_base,
  output logic       out_capture,
  output logic       pushout,
  output logic [2:0] doutix,
  output logic       busy,
  output logic       seq_err,
  output logic       ovr_err
);
  localparam int ITERS = 24 / LAYERS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_next;
  logic [4:0] iter, iter_next;
  logic [7:0] mask;
  logic       pending, done_q;
  logic       launch, last, accept, accept7, full;

  always_comb begin
    state_next = state;
    iter_next  = iter;
    core_load  = 1'b0;
    core_en    = 1'b0;
    round_base = '0;
    last       = 1'b0;
    launch     = (state == IDLE) && pending;
    // The launch cycle reads the input buffer before writes land, so the
    // next block may start arriving while the pending block is consumed.
    accept     = pushin && !(pending && !launch);
    in_we      = accept ? (8'b1 << dix) : 8'b0;
    accept7    = accept && (dix == 3'd7);
    full       = ((mask | 8'h80) == 8'hFF);
    case (state)
      IDLE: begin
        if (pending) begin
          core_load = 1'b1;
          core_en   = 1'b1;
          if (ITERS == 1) begin
            last = 1'b1;
          end else begin
            state_next = RUN;
            iter_next  = 5'd1;
          end
        end
      end
      RUN: begin
        core_en    = 1'b1;
        round_base = 5'(int'(iter) * LAYERS);
        if (iter == 5'(ITERS - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
          iter_next  = '0;
        end else begin
          iter_next = iter + 5'd1;
        end
      end
    endcase
  end

  assign busy        = pending | (state == RUN);
  assign out_capture = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      iter    <= '0;
      mask    <= '0;
      pending <= 1'b0;
      done_q  <= 1'b0;
      seq_err <= 1'b0;
      ovr_err <= 1'b0;
      pushout <= 1'b0;
      doutix  <= '0;
    end else begin
      state  <= state_next;
      iter   <= iter_next;
      done_q <= last;
      if (accept7)     mask <= '0;
      else if (accept) mask <= mask | in_we;
      // A completed block in the launch cycle refills pending immediately.
      if (accept7 && full) pending <= 1'b1;
      else if (launch)     pending <= 1'b0;
      if (accept7 && !full) seq_err <= 1'b1;
      if (pushin && !accept) ovr_err <= 1'b1;
      if (done_q) begin
        pushout <= 1'b1;
        doutix  <= '0;
      end else if (pushout && doutix != 3'd7) begin
        doutix <= doutix + 3'd1;
      end else begin
        pushout <= 1'b0;
        doutix  <= '0;
      end
    end
  end
endmodule
